// File: rtl/seq_burst_arbiter.sv
// seq_burst_arbiter: two-requester round-robin arbiter that grants a sequence generator for fixed-length bursts.
//   clk        rising-edge clock
//   clear_n    asynchronous active-low reset
//   req        per-requester burst request, held until done
//   burst_len  burst length sampled at grant (0 means 16)
//   grant      one-hot owner while running, 00 otherwise
//   seq_out    current sequence value, 00 when not valid
//   seq_valid  high on every running cycle
//   done       one-cycle end-of-burst pulse
//   aborted    qualifies done when the owner dropped its request early
//   busy       high while running or finishing a burst
module seq_burst_arbiter #(
    parameter logic [7:0] SEED     = 8'h05,
    parameter int         WRAP_LEN = 8
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic [1:0] req,
    input  logic [3:0] burst_len,
    output logic [1:0] grant,
    output logic [7:0] seq_out,
    output logic       seq_valid,
    output logic       done,
    output logic       aborted,
    output logic       busy
);

    // WRAP_LEN only documents the sequence period; the period itself follows from SEED and the update rule.
    if (WRAP_LEN < 1) begin : g_wrap_check
        $error("WRAP_LEN must be positive");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state, state_nx;
    logic [4:0] cnt, cnt_nx;
    logic       ptr, ptr_nx;
    logic [1:0] grant_nx, win;
    logic [7:0] seq_nx, seq_adv;
    logic       valid_nx, done_nx, abort_nx, busy_nx, owner_req;

    // On a tie the requester that did not own the last burst wins.
    assign win       = (req == 2'b11) ? (ptr ? 2'b01 : 2'b10) : (req[1] ? 2'b10 : 2'b01);
    assign seq_adv   = (seq_out == 8'h82) ? SEED : (seq_out == 8'hA0) ? 8'h41 : {seq_out[6:0], 1'b0};
    assign owner_req = |(req & grant);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ptr_nx   = ptr;
        grant_nx = grant;
        seq_nx   = seq_out;
        valid_nx = seq_valid;
        done_nx  = 1'b0;
        abort_nx = 1'b0;
        busy_nx  = busy;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    state_nx = RUN;
                    grant_nx = win;
                    cnt_nx   = (burst_len == 4'd0) ? 5'd16 : {1'b0, burst_len};
                    seq_nx   = SEED;
                    valid_nx = 1'b1;
                    busy_nx  = 1'b1;
                end
            end
            RUN: begin
                // A dropped owner request takes priority over normal completion.
                if (!owner_req || cnt == 5'd1) begin
                    state_nx = DONE;
                    grant_nx = 2'b00;
                    seq_nx   = 8'h00;
                    valid_nx = 1'b0;
                    done_nx  = 1'b1;
                    abort_nx = !owner_req;
                    cnt_nx   = 5'd0;
                    ptr_nx   = grant[1];
                end else begin
                    seq_nx = seq_adv;
                    cnt_nx = cnt - 5'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
            default: begin
                state_nx = IDLE;
                grant_nx = 2'b00;
                seq_nx   = 8'h00;
                valid_nx = 1'b0;
                busy_nx  = 1'b0;
                cnt_nx   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            ptr       <= 1'b1;
            grant     <= 2'b00;
            seq_out   <= 8'h00;
            seq_valid <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ptr       <= ptr_nx;
            grant     <= grant_nx;
            seq_out   <= seq_nx;
            seq_valid <= valid_nx;
            done      <= done_nx;
            aborted   <= abort_nx;
            busy      <= busy_nx;
        end
    end

endmodule

// File: tb/tb_seq_burst_arbiter.sv
// tb_seq_burst_arbiter: directed and randomized bursts checked against a transaction-level model of seq_burst_arbiter.
module tb_seq_burst_arbiter;

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [3:0] burst_len = 4'd0;
    logic [1:0] grant;
    logic [7:0] seq_out;
    logic       seq_valid, done, aborted, busy;

    int checks = 0;
    int errors = 0;
    logic ptr_m = 1'b1;
    logic [7:0] tbl [8] = '{8'h05, 8'h0A, 8'h14, 8'h28, 8'h50, 8'hA0, 8'h41, 8'h82};

    seq_burst_arbiter dut (
        .clk(clk), .clear_n(clear_n), .req(req), .burst_len(burst_len),
        .grant(grant), .seq_out(seq_out), .seq_valid(seq_valid),
        .done(done), .aborted(aborted), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [13:0] exp);
        logic [13:0] obs;
        obs = {grant, seq_out, seq_valid, done, aborted, busy};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed grant/seq/valid/done/aborted/busy=%h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one burst starting from an IDLE negedge; ab>0 drops the owner's request after ab values.
    task automatic burst(input logic [1:0] r, input int len, input int ab);
        logic [1:0] g;
        int n;
        g = (r == 2'b11) ? (ptr_m ? 2'b01 : 2'b10) : (r[1] ? 2'b10 : 2'b01);
        n = (ab != 0) ? ab : len;
        req = r;
        burst_len = 4'(len);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("run", {g, tbl[i % 8], 1'b1, 1'b0, 1'b0, 1'b1});
            burst_len = 4'($urandom);
            req = g | (2'($urandom) & ~g);
        end
        if (ab != 0) req = req & ~g;
        @(negedge clk);
        chk("done", {2'b00, 8'h00, 1'b0, 1'b1, ab != 0, 1'b1});
        ptr_m = g[1];
        @(negedge clk);
        chk("idle", 14'h0);
    endtask

    initial begin
        #12;
        chk("reset", 14'h0);
        @(negedge clk);
        clear_n = 1'b1;
        @(negedge clk);
        chk("idle_noreq", 14'h0);
        burst(2'b01, 3, 0);
        burst(2'b11, 2, 0);
        burst(2'b11, 2, 0);
        burst(2'b11, 2, 0);
        burst(2'b10, 16, 0);
        burst(2'b01, 6, 3);
        burst(2'b11, 2, 0);
        burst(2'b01, 1, 0);
        repeat (40) begin
            logic [1:0] r;
            int len, ab;
            r = 2'($urandom_range(1, 3));
            len = $urandom_range(1, 16);
            ab = (len > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : 0;
            burst(r, len, ab);
        end
        req = 2'b01;
        burst_len = 4'd5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("prereset", {2'b01, tbl[i], 1'b1, 1'b0, 1'b0, 1'b1});
        end
        #2 clear_n = 1'b0;
        #1 chk("async_clear", 14'h0);
        @(negedge clk);
        chk("clear_held", 14'h0);
        clear_n = 1'b1;
        ptr_m = 1'b1;
        burst(2'b11, 2, 0);
        burst(2'b11, 3, 0);
        req = 2'b00;
        @(negedge clk);
        chk("final_idle", 14'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
